// File: rtl/matrix_stream_loader.sv
// Stream-to-matrix loader: gathers DIM*DIM elements over valid/ready
// into a row-major flat bus, optionally transposing on ingest.
module matrix_stream_loader #(
  parameter int DIM    = 5,
  parameter int ELEM_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        col_major,
  input  logic                        in_valid,
  input  logic [ELEM_W-1:0]           in_data,
  output logic                        in_ready,
  output logic [DIM*DIM*ELEM_W-1:0]   mat_flat,
  output logic                        mat_valid,
  input  logic                        mat_ack,
  output logic                        busy,
  output logic                        err_flag
);

  localparam int FLAT_W = DIM * DIM * ELEM_W;
  localparam int CW     = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int IW     = $clog2(DIM * DIM + 1);
  localparam logic [CW-1:0] LAST = CW'(DIM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       in_cnt_q, in_cnt_d;
  logic [CW-1:0]       out_cnt_q, out_cnt_d;
  logic                cm_q, cm_d;
  logic                err_q, err_d;
  logic [FLAT_W-1:0]   mat_q, mat_d;
  logic [IW-1:0]       idx;

  // Transposed ingest swaps the roles of the two counters.
  always_comb begin
    if (cm_q) begin
      idx = IW'(in_cnt_q) * IW'(DIM) + IW'(out_cnt_q);
    end else begin
      idx = IW'(out_cnt_q) * IW'(DIM) + IW'(in_cnt_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    cm_d      = cm_q;
    err_d     = err_q;
    mat_d     = mat_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          cm_d      = col_major;
          err_d     = 1'b0;
          mat_d     = '0;
        end
      end
      LOAD: begin
        if (start) err_d = 1'b1;
        if (in_valid) begin
          for (int k = 0; k < DIM * DIM; k++) begin
            if (idx == IW'(k)) mat_d[k*ELEM_W +: ELEM_W] = in_data;
          end
          if (in_cnt_q == LAST) begin
            in_cnt_d = '0;
            if (out_cnt_q == LAST) begin
              state_d = HOLD;
            end else begin
              out_cnt_d = out_cnt_q + 1'b1;
            end
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (start) err_d = 1'b1;
        if (mat_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      cm_q      <= 1'b0;
      err_q     <= 1'b0;
      mat_q     <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      cm_q      <= cm_d;
      err_q     <= err_d;
      mat_q     <= mat_d;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign mat_valid = (state_q == HOLD);
  assign busy      = (state_q == LOAD) || (state_q == HOLD);
  assign err_flag  = err_q;
  assign mat_flat  = mat_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader: orderings, backpressure,
// hold/ack, protocol errors and asynchronous reset mid-load.
module tb_matrix_stream_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         col_major;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic [199:0] mat_flat;
  logic         mat_valid;
  logic         mat_ack;
  logic         busy;
  logic         err_flag;

  int n_cmp = 0;
  int n_bad = 0;
  logic [199:0] exp_mat;

  matrix_stream_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .col_major (col_major),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mat_flat  (mat_flat),
    .mat_valid (mat_valid),
    .mat_ack   (mat_ack),
    .busy      (busy),
    .err_flag  (err_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [199:0] got,
                       input logic [199:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic cm);
    start     = 1'b1;
    col_major = cm;
    tick();
    start     = 1'b0;
    col_major = ~cm;
    check("start_ready", in_ready, 1'b1);
    check("start_busy", busy, 1'b1);
    check("start_clear", mat_flat, '0);
  endtask

  // gap: idle cycles between beats; err_at: 1-based accept with start high;
  // stop_at: abandon after this many accepts (0 = full load)
  task automatic stream(input logic cm, input logic [7:0] base,
                        input int gap, input int err_at,
                        input int stop_at);
    int k, cyc, rdy, idx;
    logic acc;
    k = 0; cyc = 0; rdy = 0;
    exp_mat = '0;
    while (k < 25 && cyc < 300 && !(stop_at != 0 && k == stop_at)) begin
      in_valid = (gap == 0) || (cyc % (gap + 1) == 0);
      in_data  = base + 8'(k);
      start    = (err_at != 0) && (k == err_at - 1) && in_valid;
      acc      = in_valid && in_ready;
      if (in_ready) rdy++;
      if (acc) begin
        idx = cm ? ((k % 5) * 5 + k / 5) : k;
        exp_mat[idx*8 +: 8] = in_data;
        if (k == 24) check("pre_valid", mat_valid, 1'b0);
      end
      tick();
      if (start) check("err_set", err_flag, 1'b1);
      start = 1'b0;
      if (acc) k++;
      cyc++;
    end
    in_valid = 1'b0;
    if (stop_at != 0) return;
    if (k != 25) check("accept_timeout", 200'(k), 200'd25);
    if (gap == 0) check("ready_cycles", 200'(rdy), 200'd25);
    check("valid_rise", mat_valid, 1'b1);
    check("ready_drop", in_ready, 1'b0);
    check("matrix", mat_flat, exp_mat);
  endtask

  task automatic ack();
    mat_ack = 1'b1;
    tick();
    mat_ack = 1'b0;
    check("ack_valid", mat_valid, 1'b0);
    check("ack_busy", busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; col_major = 1'b0;
    in_valid = 1'b0; in_data = '0; mat_ack = 1'b0;
    #12;
    check("rst_ready", in_ready, 1'b0);
    check("rst_valid", mat_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_flag, 1'b0);
    check("rst_mat", mat_flat, '0);
    rst_n = 1'b1;
    tick();
    // ack outside HOLD is ignored
    mat_ack = 1'b1; tick(); mat_ack = 1'b0;
    check("idle_ack_err", err_flag, 1'b0);

    // 1: row-major, byte k == k
    do_start(1'b0);
    stream(1'b0, 8'd0, 0, 0, 0);
    check("row_b0", mat_flat[7:0], 8'd0);
    check("row_b24", mat_flat[199:192], 8'd24);
    ack();

    // 2: column-major transpose
    do_start(1'b1);
    stream(1'b1, 8'd0, 0, 0, 0);
    check("col_01", mat_flat[8 +: 8], 8'd5);
    check("col_10", mat_flat[40 +: 8], 8'd1);
    check("col_43", mat_flat[184 +: 8], 8'd19);
    ack();

    // 3: backpressure 1,0,0
    do_start(1'b0);
    stream(1'b0, 8'hA0, 2, 0, 0);

    // 4: hold ignores input
    in_valid = 1'b1; in_data = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("hold_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    check("hold_valid", mat_valid, 1'b1);
    check("hold_mat", mat_flat, exp_mat);
    ack();

    // 5: protocol errors
    do_start(1'b0);
    stream(1'b0, 8'h30, 0, 7, 0);
    check("err_sticky", err_flag, 1'b1);
    ack();
    mat_ack = 1'b0;
    do_start(1'b0);
    check("err_clear", err_flag, 1'b0);
    stream(1'b0, 8'h50, 0, 0, 0);
    mat_ack = 1'b1; start = 1'b1;
    tick();
    mat_ack = 1'b0; start = 1'b0;
    check("ackstart_busy", busy, 1'b0);
    check("ackstart_valid", mat_valid, 1'b0);
    check("ackstart_err", err_flag, 1'b1);
    tick();
    check("ackstart_idle", in_ready, 1'b0);

    // 6: reset mid-load after accept #12
    do_start(1'b0);
    check("err_clear2", err_flag, 1'b0);
    stream(1'b0, 8'h70, 0, 0, 12);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", in_ready, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_mat", mat_flat, '0);
    check("mid_rst_valid", mat_valid, 1'b0);
    #10;
    rst_n = 1'b1;
    tick();
    do_start(1'b0);
    stream(1'b0, 8'd0, 0, 0, 0);
    ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
